// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package mem_loader_pkg;

  localparam int unsigned MEM_A     = 6;
  localparam int unsigned MEM_W     = 8;
  localparam int unsigned MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream handshake plus single-port memory bus seen by the loader.
interface mem_loader_if
  import mem_loader_pkg::*;
#(
  parameter int unsigned A = MEM_A,
  parameter int unsigned W = MEM_W
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_loader.sv
// Streams bytes into program memory from address 0, reads them back and
// compares modular checksums, flagging error on mismatch.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned A = MEM_A,
  parameter int unsigned W = MEM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [A:0]       word_count,
  mem_loader_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [W-1:0]     checksum
);

  localparam logic [A:0] DEPTH   = {1'b1, {A{1'b0}}};
  localparam logic [A:0] CNT_ONE = (A+1)'(1);

  loader_state_t state_q, state_d;

  logic [A-1:0] addr_q;
  logic [A:0]   rem_q;
  logic [A:0]   n_q;
  logic [W-1:0] wsum_q;
  logic [W-1:0] rsum_q;
  logic         error_q;
  logic [W-1:0] cksum_q;

  logic [A:0] n_clamped;
  logic       fire;

  assign n_clamped = (word_count > DEPTH) ? DEPTH : word_count;
  assign fire      = (state_q == LOAD) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (n_clamped == '0) ? DONE : LOAD;
      LOAD:    if (fire && rem_q == CNT_ONE) state_d = VERIFY;
      VERIFY:  if (rem_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state_q)
      IDLE:   busy = 1'b0;
      LOAD: begin
        bus.in_ready = 1'b1;
        bus.mem_we   = bus.in_valid;
      end
      VERIFY: ;
      DONE:   done = 1'b1;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.in_data;
  assign error         = error_q;
  assign checksum      = cksum_q;

  // rem_q is reloaded with n on the last write so VERIFY reuses it as its cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      error_q <= 1'b0;
      cksum_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q     <= n_clamped;
            rem_q   <= n_clamped;
            addr_q  <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            error_q <= 1'b0;
          end
        end
        LOAD: begin
          if (fire) begin
            wsum_q <= wsum_q + bus.in_data;
            if (rem_q == CNT_ONE) begin
              addr_q <= '0;
              rem_q  <= n_q;
            end else begin
              addr_q <= addr_q + 1'b1;
              rem_q  <= rem_q - CNT_ONE;
            end
          end
        end
        VERIFY: begin
          rsum_q <= rsum_q + bus.mem_rdata;
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - CNT_ONE;
        end
        DONE: begin
          error_q <= (wsum_q != rsum_q);
          cksum_q <= wsum_q;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Initiator/master for the 64x8 single-port program memory.
  - That memory has a combinational read and writes on the clock edge when write-enable is high.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses from 0.
- Reads the written region back, compares an 8-bit modular checksum, then reports done or error.
- Sits between the host/boot interface and the memory; the core is held off while busy is high.

Parameters:
- A, 6, memory address width; depth is 2**A.
- W, 8, data word width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  in  A+1  number of words to load, sampled with start; values above 2**A clamp to 2**A.
- in_valid  in  1  stream byte valid.
- in_data  in  W  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  A  memory address (write address in LOAD, read address in VERIFY).
- mem_wdata  out  W  memory write data.
- mem_rdata  in  W  memory combinational read data for mem_addr.
- busy  out  1  high in LOAD, VERIFY and DONE.
- done  out  1  one-cycle pulse in DONE.
- error  out  1  checksum mismatch flag; held until the next accepted start.
- checksum  out  W  write-side checksum of the last load; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; addr, remaining count, both sums, error and checksum all 0.
  - in_ready=0, mem_we=0, busy=0, done=0 immediately, without waiting for a clock.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - On start=1, latch n=min(word_count, 2**A), clear addr and both sums, clear error.
  - If n>0 go to LOAD; if n=0 go to DONE.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - mem_we = in_valid (combinational); mem_addr = addr; mem_wdata = in_data.
  - Handshake fires when in_valid and in_ready are both high. On each fire: wsum += in_data mod 2**W, addr += 1, remaining -= 1.
  - in_valid low stalls with no write and no counter change.
  - On the fire with remaining=1: addr returns to 0 and the next state is VERIFY.
  - Addr never wraps within a load because n is clamped to 2**A. When n=2**A, the A-bit addr wraps 63->0 on the last fire, which is the required value.
- VERIFY:
  - in_ready=0, mem_we=0, mem_addr = addr.
  - Each cycle: rsum += mem_rdata, addr += 1.
  - Runs exactly n cycles; read data is valid in the same cycle because the memory read is combinational.
  - After the n-th read go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - error <= (wsum != rsum); checksum <= wsum.
  - Next state IDLE.
- Latency: start to done = 1 + (n LOAD handshake cycles, plus stalls) + n + 1 cycles.
- busy = (state != IDLE).
- Checksum arithmetic: W-bit, wraps modulo 2**W, no carry out.
- Reset mid-operation aborts the sequence. Memory contents already written stay as they are, and no done pulse is produced.

Decomposition:
- Package mem_loader_pkg holds:
  - loader_state_t enum {IDLE, LOAD, VERIFY, DONE}.
  - Constants MEM_A=6, MEM_W=8, MEM_DEPTH=64.
- No sub-module; one FSM plus counters. The bench instantiates the existing memory as the responder.

Test Plan:
- Reset mid-LOAD: after 3 writes assert rst_n=0 -> in_ready/mem_we/busy drop asynchronously, state IDLE, no done pulse.
- Basic load: start, word_count=4, stream 0x10,0x20,0x30,0x40 with in_valid always high.
  - Memory[0..3] hold those values.
  - done pulses 10 cycles after start, checksum=0xA0, error=0.
- Stalled stream: word_count=3, in_valid toggles 1,0,0,1,0,1 with data 0x01,0x02,0x03.
  - Exactly 3 writes to addresses 0,1,2, checksum=0x06.
- Full depth and clamp: word_count=100, stream 64 bytes of value 0xFF.
  - 64 writes, addr wraps to 0 for VERIFY, checksum=0xC0, error=0.
- Mismatch: during VERIFY the bench forces memory[1] to 0x00 after a load of 0x05,0x07 -> done with error=1, checksum=0x0C.
- Zero count and ignored start: word_count=0 -> DONE the next cycle, checksum=0, no writes. Also, start pulsed during LOAD -> no effect on n or addr.
